// File: rtl/pasabajas_pkg.sv
// rtl/pasabajas_pkg.sv - shared state encoding and constants for the low-pass filter sequencer
package pasabajas_pkg;

    localparam int SEL_U         = 0;
    localparam int MAC_TERMS_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLR_A,
        MAC_A,
        WR_W,
        CLR_B,
        MAC_B,
        WR_Y,
        SHIFT
    } state_t;

endpackage

// File: rtl/contador_terminos.sv
// rtl/contador_terminos.sv - MAC term index counter; holds at the terminal count instead of wrapping
module contador_terminos #(
    parameter int TERMS = 3,
    parameter int KW    = (TERMS > 1) ? $clog2(TERMS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [KW-1:0] k_o,
    output logic          tc_o
);

    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;

    assign tc_o = (k_q == KW'(TERMS - 1));
    assign k_o  = k_q;

    always_comb begin
        k_d = k_q;
        if (clr_i) begin
            k_d = '0;
        end else if (en_i && !tc_o) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/control_pasabajas.sv
// rtl/control_pasabajas.sv - biquad low-pass sequencer FSM; PASABAJAS_OVERRUN_EN adds sticky dropped-start flag
module control_pasabajas
    import pasabajas_pkg::*;
#(
    parameter int MAC_TERMS = MAC_TERMS_DEF,
    parameter int SEL_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic             rst_acum,
    output logic             leer,
    output logic             leer_y,
    output logic             desp,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int KW = (MAC_TERMS > 1) ? $clog2(MAC_TERMS) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [KW-1:0] k;
    logic          k_tc;
    logic          in_mac;
    logic          accept;

    assign in_mac = (state_q == MAC_A) || (state_q == MAC_B);
    assign accept = start && en;

    // Index is held clear outside the MAC states so each MAC phase starts at 0.
    contador_terminos #(
        .TERMS (MAC_TERMS),
        .KW    (KW)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!in_mac),
        .en_i  (in_mac),
        .k_o   (k),
        .tc_o  (k_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CLR_A;
            CLR_A:   state_d = MAC_A;
            MAC_A:   if (k_tc) state_d = WR_W;
            WR_W:    state_d = CLR_B;
            CLR_B:   state_d = MAC_B;
            MAC_B:   if (k_tc) state_d = WR_Y;
            WR_Y:    state_d = SHIFT;
            SHIFT:   state_d = accept ? CLR_A : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        sel      = SEL_W'(SEL_U);
        rst_acum = 1'b0;
        leer     = 1'b0;
        leer_y   = 1'b0;
        desp     = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE, CLR_A, CLR_B: rst_acum = 1'b1;
            MAC_A:   sel = SEL_W'(k);
            MAC_B:   sel = SEL_W'(MAC_TERMS) + SEL_W'(k);
            WR_W:    leer = 1'b1;
            WR_Y:    leer_y = 1'b1;
            SHIFT: begin
                desp = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PASABAJAS_OVERRUN_EN
    logic overrun_q;

    // SHIFT is excluded: a start there is a legal back-to-back sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (accept && (state_q != IDLE) && (state_q != SHIFT)) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_control_pasabajas.sv
// tb/tb_control_pasabajas.sv - directed vector bench for control_pasabajas
module tb_control_pasabajas;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       en;
    logic [3:0] sel;
    logic       rst_acum;
    logic       leer;
    logic       leer_y;
    logic       desp;
    logic       busy;
    logic       done;
    logic       overrun;

`ifdef PASABAJAS_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    typedef struct packed {
        logic        s;
        logic        e;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   failures;

    control_pasabajas #(.MAC_TERMS(3), .SEL_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .en       (en),
        .sel      (sel),
        .rst_acum (rst_acum),
        .leer     (leer),
        .leer_y   (leer_y),
        .desp     (desp),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {sel, rst_acum, leer, leer_y, desp, busy, done, overrun};
    endfunction

    // Output fields: sel, rst_acum, leer, leer_y, desp, busy, done, overrun
    function automatic vec_t r(input logic s, input logic e, input logic [3:0] sl,
                               input logic ra, input logic lr, input logic ly,
                               input logic dp, input logic bz, input logic dn, input logic ov);
        vec_t v;
        v.s   = s;
        v.e   = e;
        v.exp = {sl, ra, lr, ly, dp, bz, dn, ov};
        return v;
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (sel,ra,leer,leer_y,desp,busy,done,ovr)",
                     name, act, req);
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        en       = 1'b0;
        rst_n    = 1'b0;

        // Back-to-back: start at 0 and in SHIFT at 11
        tbl.push_back(r(1,1, 0,1,0,0,0,0,0,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 1,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 2,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,1,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 3,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 4,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 5,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,1,0,1,0,0));
        tbl.push_back(r(1,1, 0,0,0,0,1,1,1,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 1,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 2,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,1,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 3,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 4,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 5,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,1,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,0,1,1,1,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,0,0,0));
        // en=0 blocks start
        tbl.push_back(r(1,0, 0,1,0,0,0,0,0,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,0,0,0));
        // en dropped at cycle 3, stray start with en=0 at 6
        tbl.push_back(r(1,1, 0,1,0,0,0,0,0,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 1,0,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 2,0,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 0,0,1,0,0,1,0,0));
        tbl.push_back(r(1,0, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 3,0,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 4,0,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 5,0,0,0,0,1,0,0));
        tbl.push_back(r(0,0, 0,0,0,1,0,1,0,0));
        tbl.push_back(r(0,0, 0,0,0,0,1,1,1,0));
        tbl.push_back(r(0,0, 0,1,0,0,0,0,0,0));
        // Dropped start at cycle 4 (MAC_A) -> overrun from cycle 5 when enabled
        tbl.push_back(r(1,1, 0,1,0,0,0,0,0,0));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 1,0,0,0,0,1,0,0));
        tbl.push_back(r(1,1, 2,0,0,0,0,1,0,0));
        tbl.push_back(r(0,1, 0,0,1,0,0,1,0,OVR));
        tbl.push_back(r(0,1, 0,1,0,0,0,1,0,OVR));
        tbl.push_back(r(0,1, 3,0,0,0,0,1,0,OVR));
        tbl.push_back(r(0,1, 4,0,0,0,0,1,0,OVR));
        tbl.push_back(r(0,1, 5,0,0,0,0,1,0,OVR));
        tbl.push_back(r(0,1, 0,0,0,1,0,1,0,OVR));
        tbl.push_back(r(0,1, 0,0,0,0,1,1,1,OVR));
        tbl.push_back(r(0,1, 0,1,0,0,0,0,0,OVR));

        #1;
        check("reset_state", outs(), 11'b0000_1000000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].s;
            en    = tbl[i].e;
            check($sformatf("row%0d", i), outs(), tbl[i].exp);
        end

        // Reset during MAC_B clears everything, including sticky overrun
        @(negedge clk);
        start = 1'b1;
        en    = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_mac_b", outs(), {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OVR});
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", outs(), 11'b0000_1000000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("in_reset%0d", c), outs(), 11'b0000_1000000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("after_release", outs(), 11'b0000_1000000);
        start = 1'b1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                n = c;
                break;
            end
        end
        checks++;
        if (n != 11) begin
            failures++;
            $display("FAIL done_latency actual=%0d required=11", n);
        end
        @(negedge clk);
        check("idle_after_done", outs(), 11'b0000_1000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_pasabajas.md
CONTROL_PASABAJAS -- requirements
Module: control_pasabajas

Interface
REQ-001 Parameter MAC_TERMS, default 3, number of multiply-accumulate terms per biquad section.
REQ-002 Parameter SEL_W, default 4, width of the coefficient/operand select bus.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle strobe: new input sample uu is valid and held until done.
REQ-006 en  input  1  high enables acceptance of start; low causes start to be ignored.
REQ-007 sel  output  SEL_W  operand mux and coefficient select for the filter datapath.
REQ-008 rst_acum  output  1  synchronous clear request to the datapath accumulator.
REQ-009 leer  output  1  write of the rounded accumulator value into memory slot f.
REQ-010 leer_y  output  1  load of the rounded accumulator value into the y output register.
REQ-011 desp  output  1  delay-line shift in memory (f2<=f1, f1<=f).
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse; y is valid during and after this cycle.
REQ-014 overrun  output  1  sticky flag: start arrived while busy and was dropped.

Function
REQ-015 The FSM SHALL have states IDLE, CLR_A, MAC_A, WR_W, CLR_B, MAC_B, WR_Y, SHIFT, in this order.
REQ-016 IDLE SHALL go to CLR_A when start=1 and en=1; otherwise it SHALL stay in IDLE.
REQ-017 MAC_A and MAC_B SHALL each last exactly MAC_TERMS cycles, counted by a term index k from 0 to MAC_TERMS-1.
REQ-018 All other non-IDLE states SHALL last exactly one cycle.
REQ-019 sel SHALL equal k in MAC_A, MAC_TERMS+k in MAC_B, and 0 in all other states.
REQ-020 rst_acum SHALL be 1 in IDLE, CLR_A and CLR_B, and 0 otherwise.
REQ-021 leer SHALL be 1 only in WR_W, leer_y only in WR_Y, and desp only in SHIFT.
REQ-022 done SHALL be 1 only in SHIFT.
REQ-023 Outputs SHALL be Moore-decoded from the registered state and the term index.
REQ-024 With the default MAC_TERMS=3, done SHALL be asserted 11 cycles after the edge that samples start (CLR_A at +1, SHIFT at +11).
REQ-025 start=1 and en=1 during SHIFT SHALL go directly to CLR_A as a back-to-back sample, and SHALL NOT count as an overrun.
REQ-026 start during any other non-IDLE state SHALL be ignored, and the sequence SHALL continue unchanged.
REQ-027 Deasserting en mid-sequence SHALL NOT abort the sequence; the sequence SHALL complete through SHIFT.
REQ-028 The term index SHALL reset to 0 on entry to MAC_A and to MAC_B and SHALL NOT wrap inside a state.

Reset
REQ-029 When rst_n=0, the block SHALL immediately enter IDLE with k=0, sel=0, rst_acum=1, and leer, leer_y, desp, busy, done and overrun all at 0.
REQ-030 A reset mid-sequence SHALL abandon the sample without emitting leer, leer_y or desp; datapath memory contents are not this block's responsibility.
REQ-031 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-032 With macro PASABAJAS_OVERRUN_EN defined, overrun SHALL set on a dropped start (per REQ-026 with en=1) and SHALL clear only on reset.
REQ-033 Without PASABAJAS_OVERRUN_EN, overrun SHALL be tied to 0 and no detection logic SHALL be generated.

Structure
REQ-034 The state encoding and the constants SEL_U=0 and MAC_TERMS_DEF=3 SHALL reside in the shared package pasabajas_pkg.
REQ-035 The term index SHALL be one sub-module, contador_terminos, with clear, enable and terminal-count outputs.
REQ-036 The FSM and output decode SHALL reside in control_pasabajas.

Verification
REQ-037 Reset, then a single start at cycle 0 -> sel sequence 0,1,2 (cycles 2-4), leer@5, rst_acum@6, sel 3,4,5 (cycles 7-9), leer_y@10, desp and done @11, busy low @12.
REQ-038 start at cycle 0 and again at cycle 11 (SHIFT) -> second CLR_A at cycle 12, no overrun, two done pulses 11 cycles apart.
REQ-039 With the macro on, start at cycles 0 and 4 -> second start dropped, overrun=1 from cycle 5 until reset; with the macro off, overrun stays 0.
REQ-040 Assert rst_n=0 during MAC_B (cycle 8) -> outputs immediately take reset values, leer_y and desp never pulse, and a later start runs a full 11-cycle sequence.
REQ-041 en=0 with start pulsed -> state stays IDLE and busy=0; drop en at cycle 3 of an accepted sample -> done still at cycle 11.
